aqed_resp_fifo: RTL and testbench
=================================

Name: aqed_resp_fifo

Overview:
- Responder-side model for the A-QED memory-core harness.
- Accepts the write stream that the QED monitor issues, buffers it in order, and returns entries on read requests after a fixed latency.
- Each returned entry carries a sequence tag equal to the write index the monitor counts, so the monitor can match its orig/dup captures.
- Drives the monitor's valid_out, data_out_in and addr_in inputs; it is the producing end of that response interface.

Parameters:
- DEPTH, 16, number of FIFO entries (power of 2, at least 2)
- DATA_W, 16, data width
- TAG_W, 16, sequence tag width
- LATENCY, 2, cycles from an accepted read to valid_out (at least 1)

Ports:
- clk  in  1  single clock; one clock; reset is asynchronous and active-low
- reset  in  1  asynchronous, active-low reset
- clk_en  in  1  global advance enable; all state holds when low
- flush  in  1  synchronous clear of FIFO and pipeline contents
- wen_in  in  1  write request
- data_in  in  DATA_W  write data
- ren_in  in  1  read request
- valid_out  out  1  response valid
- data_out  out  DATA_W  response data
- addr_out  out  TAG_W  response sequence tag
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- count  out  clog2(DEPTH)+1  occupancy
- overflow  out  1  sticky: a write was dropped
- underflow  out  1  sticky: a read hit an empty FIFO

Behaviour:
- Reset (asserted low, asynchronous):
  - Clears pointers, count, wr_seq, all pipeline valids, overflow and underflow.
  - valid_out=0, data_out=0, addr_out=0, empty=1, full=0.
- Gating: nothing changes when clk_en=0. Registers hold and outputs hold their last values.
- Define push_req = clk_en & wen_in & ~flush and pop = clk_en & ren_in & ~empty & ~flush.
- wr_seq:
  - Increments (mod 2^TAG_W) on every push_req, whether or not the write is stored.
  - This keeps tags aligned with the monitor's write counter.
  - It is not changed by flush.
- Write acceptance: a write is stored when push_req & (~full | pop). The stored entry is {data_in, wr_seq}.
- Write drop: push_req & full & ~pop drops the write and sets overflow.
- Read:
  - pop removes the head entry and inserts it into pipeline stage 0.
  - ren_in while empty (clk_en=1, flush=0) sets underflow; nothing enters the pipeline.
- Simultaneous push and pop:
  - Both occur in the same cycle; count is unchanged.
  - When empty, a same-cycle write cannot be read. Reads see only entries stored before the current edge; there is no bypass.
- Pipeline:
  - LATENCY registered stages, each holding {valid, data, tag}, advancing on clk_en.
  - valid_out, data_out and addr_out come from the last stage.
  - A pop at clock edge t gives valid_out=1 after edge t+LATENCY-1 (edges counted with clk_en high), i.e. exactly LATENCY edges inclusive of the pop edge.
  - When a bubble reaches the last stage, valid_out=0. data_out and addr_out keep their last values.
- Flush (with clk_en=1):
  - Resets pointers and count, and clears all pipeline valids, so valid_out=0 next cycle.
  - Overrides any same-cycle write or read.
  - Does not clear overflow, underflow or wr_seq.
- Pointers: rd_ptr and wr_ptr are log2(DEPTH) bits and wrap naturally. count distinguishes full from empty.
- Reset mid-operation: immediate. In-flight pipeline entries are discarded and no valid_out is produced afterward.

Decomposition:
- aqed_pkg holds:
  - DATA_W and TAG_W constants
  - typedef aqed_entry_t: struct {data[DATA_W], tag[TAG_W]}
  - typedef aqed_stage_t: {valid, aqed_entry_t}
- Sub-module aqed_lat_pipe: LATENCY-stage shift register of aqed_stage_t with clk_en advance and synchronous clear.
- The top level contains the FIFO storage, pointers, counters and sticky flags.

Test Plan:
- Reset, then write 0x1234 and 0x5678, then read twice in consecutive cycles. Required: valid_out=1 two cycles after each read, with (0x1234, tag 0) then (0x5678, tag 1); count returns to 0 and empty=1.
- Write 17 values, 0x0000..0x0010, with no reads. Required: full=1 after the 16th; the 17th is dropped and overflow=1. After one read, the next write is stored with tag 17.
- ren_in while empty. Required: underflow=1, valid_out stays 0 for at least 3 cycles, count stays 0.
- FIFO full; write 0xBEEF and read in the same cycle. Required: write accepted, count stays 16, overflow stays 0; 0xBEEF is returned with tag 16 after the 16 older entries.
- 3 entries stored and 2 pops in the pipeline; assert flush for one cycle. Required: empty=1 and valid_out=0 next cycle with no late responses; the next write gets tag 5.
- Drop clk_en for 4 cycles with one entry mid-pipeline. Required: outputs frozen. After clk_en returns, valid_out rises on the remaining edge count. Async reset (low) mid-pipeline gives valid_out=0 immediately and no response after release.

Source files
------------

// File: rtl/aqed_pkg.sv
// Shared widths and entry/stage types for the A-QED responder FIFO.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package aqed_pkg;

   localparam int DATA_W = 16;
   localparam int TAG_W  = 16;

   // One buffered response: payload plus the monitor-aligned write index.
   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [TAG_W-1:0]  tag;
   } aqed_entry_t;

   // One latency-pipeline slot.
   typedef struct packed {
      logic        valid;
      aqed_entry_t entry;
   } aqed_stage_t;

endpackage

// File: rtl/aqed_lat_pipe.sv
// Fixed-latency shift register of response stages.
// Latency: LATENCY clk_en-qualified edges from stage_in to stage_out.
// Backpressure: none; advances whenever clk_en is high, clr drops all valids.
module aqed_lat_pipe
   import aqed_pkg::*;
#(
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        clk_en,
   input  logic        clr,
   input  aqed_stage_t stage_in,
   output aqed_stage_t stage_out
);

   aqed_stage_t stage_q [LATENCY];

   // Shift valids every enabled edge; payload only moves with a valid so the
   // last stage keeps presenting the most recent response across bubbles.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage_q[i] <= '0;
         end
      end else if (clk_en) begin
         if (clr) begin
            for (int i = 0; i < LATENCY; i++) begin
               stage_q[i].valid <= 1'b0;
            end
         end else begin
            stage_q[0].valid <= stage_in.valid;
            if (stage_in.valid) begin
               stage_q[0].entry <= stage_in.entry;
            end
            for (int i = 1; i < LATENCY; i++) begin
               stage_q[i].valid <= stage_q[i-1].valid;
               if (stage_q[i-1].valid) begin
                  stage_q[i].entry <= stage_q[i-1].entry;
               end
            end
         end
      end
   end

   assign stage_out = stage_q[LATENCY-1];

endmodule

// File: rtl/aqed_resp_fifo.sv
// Responder FIFO for the A-QED harness: buffers writes in order, tags them with the write index.
// Latency: a pop returns its entry on valid_out LATENCY enabled edges later (pop edge inclusive).
// Backpressure: none; writes to a full FIFO (without a same-cycle pop) are dropped and flagged sticky.
module aqed_resp_fifo
   import aqed_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int LATENCY = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      clk_en,
   input  logic                      flush,
   input  logic                      wen_in,
   input  logic [DATA_W-1:0]         data_in,
   input  logic                      ren_in,
   output logic                      valid_out,
   output logic [DATA_W-1:0]         data_out,
   output logic [TAG_W-1:0]          addr_out,
   output logic                      full,
   output logic                      empty,
   output logic [$clog2(DEPTH):0]    count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic [TAG_W-1:0] wr_seq;
   aqed_entry_t      mem [DEPTH];

   logic        push_req;
   logic        pop;
   logic        store;
   logic        drop;
   logic        rd_miss;
   aqed_stage_t pipe_in;
   aqed_stage_t pipe_out;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign count = count_q;

   // A pop frees the head this edge, so a full FIFO still accepts a same-cycle write.
   assign push_req = clk_en & wen_in & ~flush;
   assign pop      = clk_en & ren_in & ~empty & ~flush;
   assign store    = push_req & (~full | pop);
   assign drop     = push_req & full & ~pop;
   assign rd_miss  = clk_en & ren_in & empty & ~flush;

   // Pointers and occupancy; flush returns the FIFO to empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (clk_en) begin
         if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
         end else begin
            if (store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (store && !pop)      count_q <= count_q + 1'b1;
            else if (!store && pop) count_q <= count_q - 1'b1;
         end
      end
   end

   // Write index tracks every write request, stored or dropped, and survives flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_seq <= '0;
      end else if (push_req) begin
         wr_seq <= wr_seq + 1'b1;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (drop)    overflow  <= 1'b1;
         if (rd_miss) underflow <= 1'b1;
      end
   end

   // Entry storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk) begin
      if (store) begin
         mem[wr_ptr] <= {data_in, wr_seq};
      end
   end

   // Head is read before the edge, so a same-cycle write is never bypassed.
   assign pipe_in = {pop, mem[rd_ptr]};

   aqed_lat_pipe #(
      .LATENCY (LATENCY)
   ) u_lat_pipe (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .clr       (flush),
      .stage_in  (pipe_in),
      .stage_out (pipe_out)
   );

   assign valid_out = pipe_out.valid;
   assign data_out  = pipe_out.entry.data;
   assign addr_out  = pipe_out.entry.tag;

endmodule

// File: tb/tb_aqed_resp_fifo.sv
// Self-checking bench for aqed_resp_fifo with a scoreboard of expected responses.
// Latency: responses are expected LAT enabled edges after each modelled pop.
// Backpressure: overflow/underflow and clk_en gating exercised by scenario tasks.
module tb_aqed_resp_fifo;

   localparam int DEPTH = 16;
   localparam int LAT   = 2;

   typedef struct {
      int          due;
      logic [15:0] d;
      logic [15:0] t;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        flush;
   logic        wen_in;
   logic [15:0] data_in;
   logic        ren_in;
   logic        valid_out;
   logic [15:0] data_out;
   logic [15:0] addr_out;
   logic        full;
   logic        empty;
   logic [4:0]  count;
   logic        overflow;
   logic        underflow;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   logic [31:0] mq[$];
   exp_t        exp_q[$];
   int          ecount;
   logic [15:0] mseq;
   logic        m_over, m_under, m_vout;
   logic [15:0] m_dout, m_aout;

   always #5 clk = ~clk;

   aqed_resp_fifo #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
      .clk       (clk),
      .reset     (reset),
      .clk_en    (clk_en),
      .flush     (flush),
      .wen_in    (wen_in),
      .data_in   (data_in),
      .ren_in    (ren_in),
      .valid_out (valid_out),
      .data_out  (data_out),
      .addr_out  (addr_out),
      .full      (full),
      .empty     (empty),
      .count     (count),
      .overflow  (overflow),
      .underflow (underflow)
   );

   function automatic void model_clear();
      mq.delete();
      exp_q.delete();
      ecount  = 0;
      mseq    = '0;
      m_over  = 1'b0;
      m_under = 1'b0;
      m_vout  = 1'b0;
      m_dout  = '0;
      m_aout  = '0;
   endfunction

   // One clock: drive at negedge, update model at posedge, compare all outputs #1 later.
   task automatic step(input logic en, input logic w, input logic [15:0] d,
                       input logic r, input logic f);
      exp_t        e;
      logic [31:0] ent;
      bit          full0, popm;
      @(negedge clk);
      clk_en = en; wen_in = w; data_in = d; ren_in = r; flush = f;
      @(posedge clk);
      if (en) begin
         ecount++;
         if (f) begin
            mq.delete();
            exp_q.delete();
         end else begin
            full0 = (mq.size() == DEPTH);
            popm  = r && (mq.size() != 0);
            if (r && mq.size() == 0) m_under = 1'b1;
            if (popm) begin
               ent   = mq.pop_front();
               e.due = ecount + LAT - 1;
               e.d   = ent[31:16];
               e.t   = ent[15:0];
               exp_q.push_back(e);
            end
            if (w) begin
               if (!full0 || popm) mq.push_back({d, mseq});
               else m_over = 1'b1;
               mseq++;
            end
         end
         m_vout = 1'b0;
         if (exp_q.size() > 0 && exp_q[0].due == ecount) begin
            e      = exp_q.pop_front();
            m_vout = 1'b1;
            m_dout = e.d;
            m_aout = e.t;
         end
      end
      #1;
      n_checks++;
      if (valid_out !== m_vout) begin
         n_fail++; $display("FAIL valid_out t=%0t got=%b exp=%b", $time, valid_out, m_vout);
      end
      n_checks++;
      if (data_out !== m_dout) begin
         n_fail++; $display("FAIL data_out t=%0t got=%h exp=%h", $time, data_out, m_dout);
      end
      n_checks++;
      if (addr_out !== m_aout) begin
         n_fail++; $display("FAIL addr_out t=%0t got=%h exp=%h", $time, addr_out, m_aout);
      end
      n_checks++;
      if (count !== 5'(mq.size())) begin
         n_fail++; $display("FAIL count t=%0t got=%0d exp=%0d", $time, count, mq.size());
      end
      n_checks++;
      if (empty !== (mq.size() == 0) || full !== (mq.size() == DEPTH)) begin
         n_fail++; $display("FAIL empty_full t=%0t got=%b%b exp=%b%b", $time, empty, full,
                            mq.size() == 0, mq.size() == DEPTH);
      end
      n_checks++;
      if (overflow !== m_over || underflow !== m_under) begin
         n_fail++; $display("FAIL sticky t=%0t got=%b%b exp=%b%b", $time, overflow, underflow,
                            m_over, m_under);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
   endtask

   // Asynchronous reset asserted between edges; outputs must clear at once.
   task automatic do_reset();
      @(negedge clk);
      clk_en = 1'b1; wen_in = 1'b0; ren_in = 1'b0; flush = 1'b0; data_in = '0;
      #2 reset = 1'b0;
      #1;
      model_clear();
      n_checks++;
      if (valid_out !== 1'b0 || data_out !== 16'h0 || addr_out !== 16'h0) begin
         n_fail++; $display("FAIL reset_outputs got v=%b d=%h a=%h exp 0/0000/0000",
                            valid_out, data_out, addr_out);
      end
      n_checks++;
      if (empty !== 1'b1 || full !== 1'b0 || count !== 5'd0) begin
         n_fail++; $display("FAIL reset_status got e=%b f=%b c=%0d exp 1/0/0", empty, full, count);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      idle(2);
   endtask

   task automatic test_basic();
      do_reset();
      step(1, 1, 16'h1234, 0, 0);
      step(1, 1, 16'h5678, 0, 0);
      step(1, 0, 16'h0, 1, 0);
      step(1, 0, 16'h0, 1, 0);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 16'h1234 || addr_out !== 16'd0) begin
         n_fail++; $display("FAIL basic_first got v=%b d=%h a=%0d exp 1/1234/0",
                            valid_out, data_out, addr_out);
      end
      idle(1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 16'h5678 || addr_out !== 16'd1) begin
         n_fail++; $display("FAIL basic_second got v=%b d=%h a=%0d exp 1/5678/1",
                            valid_out, data_out, addr_out);
      end
      idle(2);
      n_checks++;
      if (count !== 5'd0 || empty !== 1'b1) begin
         n_fail++; $display("FAIL basic_drained got c=%0d e=%b exp 0/1", count, empty);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(1, 1, 16'(i), 0, 0);
         if (i == 15) begin
            n_checks++;
            if (full !== 1'b1 || overflow !== 1'b0) begin
               n_fail++; $display("FAIL ovf_full got f=%b o=%b exp 1/0", full, overflow);
            end
         end
      end
      n_checks++;
      if (overflow !== 1'b1 || count !== 5'd16) begin
         n_fail++; $display("FAIL ovf_drop got o=%b c=%0d exp 1/16", overflow, count);
      end
      step(1, 0, 16'h0, 1, 0);
      step(1, 1, 16'hAAAA, 0, 0);
      for (int i = 0; i < 16; i++) step(1, 0, 16'h0, 1, 0);
      idle(1);
      n_checks++;
      if (data_out !== 16'hAAAA || addr_out !== 16'd17) begin
         n_fail++; $display("FAIL ovf_tag17 got d=%h a=%0d exp AAAA/17", data_out, addr_out);
      end
   endtask

   task automatic test_underflow();
      do_reset();
      step(1, 0, 16'h0, 1, 0);
      n_checks++;
      if (underflow !== 1'b1) begin
         n_fail++; $display("FAIL underflow_flag got=%b exp=1", underflow);
      end
      for (int i = 0; i < 3; i++) begin
         idle(1);
         n_checks++;
         if (valid_out !== 1'b0 || count !== 5'd0) begin
            n_fail++; $display("FAIL underflow_quiet got v=%b c=%0d exp 0/0", valid_out, count);
         end
      end
   endtask

   task automatic test_full_rw();
      do_reset();
      for (int i = 0; i < 16; i++) step(1, 1, 16'h0100 + 16'(i), 0, 0);
      step(1, 1, 16'hBEEF, 1, 0);
      n_checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
         n_fail++; $display("FAIL fullrw_state got c=%0d o=%b f=%b exp 16/0/1", count, overflow, full);
      end
      for (int i = 0; i < 16; i++) step(1, 0, 16'h0, 1, 0);
      idle(1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 16'hBEEF || addr_out !== 16'd16) begin
         n_fail++; $display("FAIL fullrw_beef got v=%b d=%h a=%0d exp 1/BEEF/16",
                            valid_out, data_out, addr_out);
      end
      idle(2);
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 1, 16'h0A00 + 16'(i), 0, 0);
      step(1, 0, 16'h0, 1, 0);
      step(1, 0, 16'h0, 1, 0);
      step(1, 1, 16'hDEAD, 1, 1);
      n_checks++;
      if (empty !== 1'b1 || valid_out !== 1'b0) begin
         n_fail++; $display("FAIL flush_clear got e=%b v=%b exp 1/0", empty, valid_out);
      end
      for (int i = 0; i < 3; i++) begin
         idle(1);
         n_checks++;
         if (valid_out !== 1'b0) begin
            n_fail++; $display("FAIL flush_late got v=%b exp 0", valid_out);
         end
      end
      step(1, 1, 16'h7777, 0, 0);
      step(1, 0, 16'h0, 1, 0);
      idle(1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 16'h7777 || addr_out !== 16'd5) begin
         n_fail++; $display("FAIL flush_tag5 got v=%b d=%h a=%0d exp 1/7777/5",
                            valid_out, data_out, addr_out);
      end
   endtask

   task automatic test_clk_en();
      do_reset();
      step(1, 1, 16'hC001, 0, 0);
      step(1, 1, 16'hC002, 0, 0);
      step(1, 0, 16'h0, 1, 0);
      step(1, 0, 16'h0, 1, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 16'hFFFF, 1, 1);
         n_checks++;
         if (valid_out !== 1'b1 || data_out !== 16'hC001 || count !== 5'd0) begin
            n_fail++; $display("FAIL clken_frozen got v=%b d=%h c=%0d exp 1/C001/0",
                               valid_out, data_out, count);
         end
      end
      idle(1);
      n_checks++;
      if (valid_out !== 1'b1 || data_out !== 16'hC002 || addr_out !== 16'd1) begin
         n_fail++; $display("FAIL clken_resume got v=%b d=%h a=%0d exp 1/C002/1",
                            valid_out, data_out, addr_out);
      end
      idle(1);
   endtask

   task automatic test_async_reset();
      do_reset();
      step(1, 1, 16'hD001, 0, 0);
      step(1, 1, 16'hD002, 0, 0);
      step(1, 0, 16'h0, 1, 0);
      step(1, 0, 16'h0, 1, 0);
      do_reset();
      for (int i = 0; i < 4; i++) begin
         idle(1);
         n_checks++;
         if (valid_out !== 1'b0) begin
            n_fail++; $display("FAIL arst_late got v=%b exp 0", valid_out);
         end
      end
   endtask

   initial begin
      reset = 1'b1; clk_en = 1'b0; flush = 1'b0; wen_in = 1'b0; ren_in = 1'b0; data_in = '0;
      model_clear();
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_full_rw();
      test_flush();
      test_clk_en();
      test_async_reset();
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
